// File: rtl/uart_tx_fifo_if.sv
// Transmit-side bus of the UART TX block.
//   tx_data/tx_valid/tx_ready : byte enqueue handshake (push on valid && ready)
//   TXD                       : serial line, idle high
//   tx_busy                   : high while a frame is on the line
//   frame_done                : one-cycle pulse on the last cycle of each stop bit
//   fifo_count                : bytes queued, excluding the byte in flight
// master = byte producer, slave = the transmitter.
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 4
);
    logic [7:0]                  tx_data;
    logic                        tx_valid;
    logic                        tx_ready;
    logic                        TXD;
    logic                        tx_busy;
    logic                        frame_done;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, TXD, tx_busy, frame_done, fifo_count
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, TXD, tx_busy, frame_done, fifo_count
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter with a small byte FIFO in front of it.
// Bytes are queued through the tx bus and serialised LSB first onto TXD,
// each bit held for CLKS_PER_BIT clocks. Frames go out back to back with
// no idle gap while the FIFO holds data.
// Ports:
//   CLK   : system clock, rising edge
//   RESET : asynchronous active-low reset; aborts any frame, empties FIFO
//   tx    : uart_tx_fifo_if slave (handshake, TXD, status)
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 16
) (
    input  logic          CLK,
    input  logic          RESET,
    uart_tx_fifo_if.slave tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // FIFO
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, push, pop;

    // serialiser
    state_t        state, state_nx;
    logic          txd, txd_nx;
    logic          busy, busy_nx;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_nx;
    logic [2:0]    bit_idx, bit_idx_nx;
    logic [7:0]    shift, shift_nx;
    logic          bit_end;

    // Ready comes from the registered count only, so a pop in the same
    // cycle never opens the door for a push into a full FIFO.
    assign full    = (count == CW'(FIFO_DEPTH));
    assign push    = tx.tx_valid && !full;
    assign bit_end = (bit_cnt == LAST);

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= tx.tx_data;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            txd     <= 1'b1;
            busy    <= 1'b0;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_nx;
            txd     <= txd_nx;
            busy    <= busy_nx;
            bit_cnt <= bit_cnt_nx;
            bit_idx <= bit_idx_nx;
            shift   <= shift_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        txd_nx     = txd;
        bit_cnt_nx = bit_cnt + CNT_W'(1);
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                bit_cnt_nx = '0;
                txd_nx     = 1'b1;
                if (count != '0) begin
                    pop      = 1'b1;
                    shift_nx = mem[rd_ptr];
                    txd_nx   = 1'b0;
                    state_nx = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_cnt_nx = '0;
                    bit_idx_nx = '0;
                    txd_nx     = shift[0];
                    state_nx   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_nx = '0;
                    if (bit_idx == 3'd7) begin
                        txd_nx   = 1'b1;
                        state_nx = STOP;
                    end else begin
                        // shift[1] is what shift[0] becomes after the shift
                        shift_nx   = shift >> 1;
                        txd_nx     = shift[1];
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    bit_cnt_nx = '0;
                    if (count != '0) begin
                        // next start bit follows the stop bit directly
                        pop      = 1'b1;
                        shift_nx = mem[rd_ptr];
                        txd_nx   = 1'b0;
                        state_nx = START;
                    end else begin
                        txd_nx   = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                bit_cnt_nx = '0;
                txd_nx     = 1'b1;
                state_nx   = IDLE;
            end
        endcase
        busy_nx = (state_nx != IDLE);
    end

    assign tx.tx_ready   = !full;
    assign tx.TXD        = txd;
    assign tx.tx_busy    = busy;
    assign tx.frame_done = (state == STOP) && bit_end;
    assign tx.fifo_count = count;
endmodule
